// File: rtl/dzcpu_ucode_pkg.sv
// rtl/dzcpu_ucode_pkg.sv - flow-control codes and sequencer state encoding for the micro-op sequencer
// INT state exists only when DZCPU_UCODE_INT_EN is defined.
package dzcpu_ucode_pkg;

    localparam int FC_W = 3;

    localparam logic [FC_W-1:0] FC_OP     = 3'd0;
    localparam logic [FC_W-1:0] FC_EOF    = 3'd1;
    localparam logic [FC_W-1:0] FC_EOF_Z  = 3'd2;
    localparam logic [FC_W-1:0] FC_EOF_NZ = 3'd3;
    localparam logic [FC_W-1:0] FC_JCB    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1
`ifdef DZCPU_UCODE_INT_EN
        ,
        ST_INT  = 2'd2
`endif
    } seq_state_e;

endpackage

// File: rtl/dzcpu_ucode_seq_if.sv
// rtl/dzcpu_ucode_seq_if.sv - macro-op / micro-op handshake bundle of the sequencer
// iIrq is present only when DZCPU_UCODE_INT_EN is defined.
interface dzcpu_ucode_seq_if #(
    parameter int UOP_W  = 13,
    parameter int ADDR_W = 8
);
    logic              iMopValid;
    logic              oMopReady;
    logic [7:0]        iMop;
    logic [7:0]        iCbOp;
    logic              iFlagZ;
    logic              oUopValid;
    logic              iUopReady;
    logic [UOP_W-1:0]  oUop;
    logic [ADDR_W-1:0] oUpc;
    logic              oUpcOvf;
`ifdef DZCPU_UCODE_INT_EN
    logic              iIrq;
`endif

    modport slave (
`ifdef DZCPU_UCODE_INT_EN
        input  iIrq,
`endif
        input  iMopValid, iMop, iCbOp, iFlagZ, iUopReady,
        output oMopReady, oUopValid, oUop, oUpc, oUpcOvf
    );

    modport master (
`ifdef DZCPU_UCODE_INT_EN
        output iIrq,
`endif
        output iMopValid, iMop, iCbOp, iFlagZ, iUopReady,
        input  oMopReady, oUopValid, oUop, oUpc, oUpcOvf
    );

endinterface

// File: rtl/dzcpu_ucode_mem.sv
// rtl/dzcpu_ucode_mem.sv - combinational main LUT, CB LUT and micro-op ROM
// Payload bits are a fixed function of the address so every ROM word is distinct.
module dzcpu_ucode_mem
    import dzcpu_ucode_pkg::*;
#(
    parameter int                UOP_W   = 13,
    parameter int                ADDR_W  = 8,
    parameter logic [ADDR_W-1:0] INT_IDX = '0
) (
    input  logic [7:0]        mop,
    input  logic [7:0]        cb_op,
    input  logic [ADDR_W-1:0] rom_addr,
    output logic [ADDR_W-1:0] main_idx,
    output logic [ADDR_W-1:0] cb_idx,
    output logic [UOP_W-1:0]  rom_data
);

    logic [FC_W-1:0]       fc;
    logic [UOP_W-FC_W-1:0] payload;

    always_comb begin
        main_idx = '0;
        case (mop)
            8'h01:   main_idx = ADDR_W'(1);
            8'h20:   main_idx = ADDR_W'(5);
            8'h28:   main_idx = ADDR_W'(13);
            8'hCB:   main_idx = ADDR_W'(11);
            8'h76:   main_idx = ADDR_W'(17);
            8'hFF:   main_idx = ADDR_W'(253);
            default: main_idx = '0;
        endcase
    end

    always_comb begin
        cb_idx = '0;
        case (cb_op)
            8'h7C:   cb_idx = ADDR_W'(16);
            8'h40:   cb_idx = ADDR_W'(18);
            default: cb_idx = '0;
        endcase
    end

    // Anything not listed is an EOF word, so a stray jump always terminates.
    always_comb begin
        fc = FC_EOF;
        if (rom_addr == INT_IDX || rom_addr == INT_IDX + ADDR_W'(1)) begin
            fc = FC_OP;
        end else begin
            case (rom_addr)
                ADDR_W'(1), ADDR_W'(2), ADDR_W'(3), ADDR_W'(5), ADDR_W'(6),
                ADDR_W'(8), ADDR_W'(9), ADDR_W'(11), ADDR_W'(13), ADDR_W'(18),
                ADDR_W'(253), ADDR_W'(254), ADDR_W'(255): fc = FC_OP;
                ADDR_W'(7):  fc = FC_EOF_Z;
                ADDR_W'(14): fc = FC_EOF_NZ;
                ADDR_W'(12): fc = FC_JCB;
                ADDR_W'(17): fc = 3'd7;
                default:     fc = FC_EOF;
            endcase
        end
    end

    assign payload  = (UOP_W-FC_W)'(32'(rom_addr) * 32'd37 + 32'd5);
    assign rom_data = {fc, payload};

endmodule

// File: rtl/dzcpu_ucode_seq.sv
// rtl/dzcpu_ucode_seq.sv - micro-op sequencer: expands macro-ops into ROM micro-op flows
// Optional interrupt-flow entry at flow end is enabled by DZCPU_UCODE_INT_EN.
module dzcpu_ucode_seq
    import dzcpu_ucode_pkg::*;
#(
    parameter int                UOP_W        = 13,
    parameter int                ADDR_W       = 8,
    parameter logic [ADDR_W-1:0] INT_FLOW_IDX = 8'd163
) (
    input  logic              iClock,
    input  logic              iReset,
    dzcpu_ucode_seq_if.slave  bus
);

    seq_state_e        state_q, state_d;
    logic [ADDR_W-1:0] upc_q, upc_d;
    logic [UOP_W-1:0]  uop_q, uop_d;
    logic              valid_q, valid_d;
    logic              ovf_q, ovf_d;

    logic [ADDR_W-1:0] main_idx, cb_idx, rom_addr;
    logic [UOP_W-1:0]  rom_data;
    logic [FC_W-1:0]   fc;
    logic              flow_end, jump;

    dzcpu_ucode_mem #(
        .UOP_W   (UOP_W),
        .ADDR_W  (ADDR_W),
        .INT_IDX (INT_FLOW_IDX)
    ) u_mem (
        .mop      (bus.iMop),
        .cb_op    (bus.iCbOp),
        .rom_addr (rom_addr),
        .main_idx (main_idx),
        .cb_idx   (cb_idx),
        .rom_data (rom_data)
    );

    assign fc = uop_q[UOP_W-1 -: FC_W];

    always_comb begin
        flow_end = 1'b0;
        jump     = 1'b0;
        case (fc)
            FC_OP:     flow_end = 1'b0;
            FC_EOF_Z:  flow_end = bus.iFlagZ;
            FC_EOF_NZ: flow_end = !bus.iFlagZ;
            FC_JCB:    jump     = 1'b1;
            default:   flow_end = 1'b1;
        endcase
    end

    // The ROM is read at the next uPC so a completing micro-op is replaced on the same edge.
    always_comb begin
        rom_addr = upc_q;
        if (state_q != ST_IDLE && valid_q && bus.iUopReady && !flow_end)
            rom_addr = jump ? cb_idx : upc_q + ADDR_W'(1);
    end

    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        uop_d   = uop_q;
        valid_d = valid_q;
        ovf_d   = ovf_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.iMopValid) begin
                    state_d = ST_RUN;
                    upc_d   = main_idx;
                end
            end
            default: begin
                if (!valid_q) begin
                    uop_d   = rom_data;
                    valid_d = 1'b1;
                end else if (bus.iUopReady) begin
                    if (flow_end) begin
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
`ifdef DZCPU_UCODE_INT_EN
                        if (state_q == ST_RUN && bus.iIrq) begin
                            state_d = ST_INT;
                            upc_d   = INT_FLOW_IDX;
                        end
`endif
                    end else if (!jump && upc_q == '1) begin
                        ovf_d   = 1'b1;
                        valid_d = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        upc_d = rom_addr;
                        uop_d = rom_data;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= ST_IDLE;
            upc_q   <= '0;
            uop_q   <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            uop_q   <= uop_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.oMopReady = (state_q == ST_IDLE);
    assign bus.oUopValid = valid_q;
    assign bus.oUop      = uop_q;
    assign bus.oUpc      = upc_q;
    assign bus.oUpcOvf   = ovf_q;

endmodule

// File: tb/tb_dzcpu_ucode_seq.sv
// tb/tb_dzcpu_ucode_seq.sv - self-checking bench for dzcpu_ucode_seq with a flow-level reference model
// Interrupt scenario is compiled in when DZCPU_UCODE_INT_EN is defined.
module tb_dzcpu_ucode_seq;

    logic iClock = 1'b0;
    logic iReset = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   got_q[$];
    bit   col_to;
    int   exp_q[$];
    bit   exp_ovf;

    always #5 iClock = ~iClock;

    dzcpu_ucode_seq_if #(.UOP_W(13), .ADDR_W(8)) bus ();

    dzcpu_ucode_seq #(.UOP_W(13), .ADDR_W(8), .INT_FLOW_IDX(8'd163)) dut (
        .iClock (iClock),
        .iReset (iReset),
        .bus    (bus)
    );

    function automatic int lut_main(input logic [7:0] op);
        case (op)
            8'h01: return 1;
            8'h20: return 5;
            8'h28: return 13;
            8'hCB: return 11;
            8'h76: return 17;
            8'hFF: return 253;
            default: return 0;
        endcase
    endfunction

    function automatic int lut_cb(input logic [7:0] op);
        case (op)
            8'h7C: return 16;
            8'h40: return 18;
            default: return 0;
        endcase
    endfunction

    function automatic int fc_of(input int a);
        case (a)
            1, 2, 3, 5, 6, 8, 9, 11, 13, 18, 163, 164, 253, 254, 255: return 0;
            7:  return 2;
            14: return 3;
            12: return 4;
            17: return 7;
            default: return 1;
        endcase
    endfunction

    function automatic logic [12:0] exp_uop(input int a);
        logic [9:0] p;
        p = 10'(a * 37 + 5);
        return {3'(fc_of(a)), p};
    endfunction

    // Walks a flow by the sequencing rules and records the uPC of every issued micro-op.
    task automatic model_flow(input logic [7:0] op, input logic [7:0] cb, input bit z, input bit irq);
        int pc, f;
        bit in_int, ends;
        exp_q = {};
        exp_ovf = 0;
        in_int = 0;
        pc = lut_main(op);
        for (int n = 0; n < 300; n++) begin
            exp_q.push_back(pc);
            f = fc_of(pc);
            ends = (f == 1) || (f >= 5) || (f == 2 && z) || (f == 3 && !z);
            if (ends) begin
                if (irq && !in_int) begin
                    in_int = 1;
                    pc = 163;
                end else begin
                    break;
                end
            end else if (f == 4) begin
                pc = lut_cb(cb);
            end else if (pc == 255) begin
                exp_ovf = 1;
                break;
            end else begin
                pc++;
            end
        end
    endtask

    function automatic string got_str();
        string s = "";
        foreach (got_q[i]) s = {s, (i == 0) ? "" : " ", $sformatf("%0d", got_q[i])};
        return s;
    endfunction

    task automatic step();
        @(posedge iClock);
        #1;
    endtask

    task automatic accept(input logic [7:0] op);
        int n = 0;
        while (!bus.oMopReady && n < 50) begin
            step();
            n++;
        end
        checks++;
        if (n >= 50) begin
            errors++;
            $display("FAIL accept_wait op=%h oMopReady stayed 0 for %0d cycles, expected 1", op, n);
        end
        bus.iMop = op;
        bus.iMopValid = 1'b1;
        step();
        bus.iMopValid = 1'b0;
    endtask

    // With iUopReady held high, gathers oUpc of each issued micro-op until the sequencer is idle.
    task automatic collect();
        got_q = {};
        col_to = 1;
        for (int i = 0; i < 100; i++) begin
            if (bus.oUopValid) got_q.push_back(int'(bus.oUpc));
            else if (bus.oMopReady) begin
                col_to = 0;
                break;
            end
            step();
        end
    endtask

    task automatic do_reset();
        iReset = 1'b1;
        step();
        iReset = 1'b0;
    endtask

    task automatic test_reset();
        bus.iMopValid = 0; bus.iMop = 0; bus.iCbOp = 0; bus.iFlagZ = 0; bus.iUopReady = 0;
`ifdef DZCPU_UCODE_INT_EN
        bus.iIrq = 0;
`endif
        step();
        do_reset();
        checks += 5;
        if (bus.oMopReady !== 1'b1) begin errors++; $display("FAIL reset_mop_ready got=%b exp=1", bus.oMopReady); end
        if (bus.oUopValid !== 1'b0) begin errors++; $display("FAIL reset_uop_valid got=%b exp=0", bus.oUopValid); end
        if (bus.oUop !== 13'd0) begin errors++; $display("FAIL reset_uop got=%h exp=0", bus.oUop); end
        if (bus.oUpc !== 8'd0) begin errors++; $display("FAIL reset_upc got=%0d exp=0", bus.oUpc); end
        if (bus.oUpcOvf !== 1'b0) begin errors++; $display("FAIL reset_ovf got=%b exp=0", bus.oUpcOvf); end
    endtask

    task automatic test_single_op();
        bus.iUopReady = 1;
        accept(8'h00);
        checks += 6;
        if (bus.oUopValid !== 1'b0) begin errors++; $display("FAIL nop_latency valid got=%b exp=0", bus.oUopValid); end
        step();
        if (bus.oUopValid !== 1'b1) begin errors++; $display("FAIL nop_valid got=%b exp=1", bus.oUopValid); end
        if (bus.oUpc !== 8'd0) begin errors++; $display("FAIL nop_upc got=%0d exp=0", bus.oUpc); end
        if (bus.oUop !== exp_uop(0)) begin errors++; $display("FAIL nop_uop got=%h exp=%h", bus.oUop, exp_uop(0)); end
        step();
        if (bus.oUopValid !== 1'b0) begin errors++; $display("FAIL nop_one_cycle valid got=%b exp=0", bus.oUopValid); end
        if (bus.oMopReady !== 1'b1) begin errors++; $display("FAIL nop_mop_ready got=%b exp=1", bus.oMopReady); end
    endtask

    task automatic test_backpressure();
        logic [12:0] held;
        bus.iUopReady = 0;
        accept(8'h01);
        step();
        held = bus.oUop;
        checks += 2;
        if (bus.oUopValid !== 1'b1 || bus.oUpc !== 8'd1) begin
            errors++; $display("FAIL bp_first valid=%b upc=%0d exp valid=1 upc=1", bus.oUopValid, bus.oUpc);
        end
        if (held !== exp_uop(1)) begin errors++; $display("FAIL bp_first_uop got=%h exp=%h", held, exp_uop(1)); end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.oUopValid !== 1'b1 || bus.oUpc !== 8'd1 || bus.oUop !== held) begin
                errors++;
                $display("FAIL bp_hold cycle=%0d valid=%b upc=%0d uop=%h exp valid=1 upc=1 uop=%h",
                         i, bus.oUopValid, bus.oUpc, bus.oUop, held);
            end
        end
        bus.iUopReady = 1;
        for (int i = 1; i <= 4; i++) begin
            checks++;
            if (bus.oUopValid !== 1'b1 || bus.oUpc !== 8'(i) || bus.oUop !== exp_uop(i)) begin
                errors++;
                $display("FAIL bp_stream valid=%b upc=%0d uop=%h exp valid=1 upc=%0d uop=%h",
                         bus.oUopValid, bus.oUpc, bus.oUop, i, exp_uop(i));
            end
            step();
        end
        checks++;
        if (bus.oUopValid !== 1'b0 || bus.oMopReady !== 1'b1) begin
            errors++; $display("FAIL bp_end valid=%b mop_ready=%b exp 0/1", bus.oUopValid, bus.oMopReady);
        end
    endtask

    task automatic test_cond_end();
        bus.iUopReady = 1;
        bus.iFlagZ = 1;
        accept(8'h20);
        collect();
        checks++;
        if (col_to || got_str() != "5 6 7") begin errors++; $display("FAIL jr_z1 got=\"%s\" to=%b exp=\"5 6 7\"", got_str(), col_to); end
        bus.iFlagZ = 0;
        accept(8'h20);
        collect();
        checks++;
        if (col_to || got_str() != "5 6 7 8 9 10") begin errors++; $display("FAIL jr_z0 got=\"%s\" to=%b exp=\"5 6 7 8 9 10\"", got_str(), col_to); end
        bus.iFlagZ = 0;
        accept(8'h28);
        collect();
        checks++;
        if (col_to || got_str() != "13 14") begin errors++; $display("FAIL jrnz_z0 got=\"%s\" to=%b exp=\"13 14\"", got_str(), col_to); end
        accept(8'h76);
        collect();
        checks++;
        if (col_to || got_str() != "17") begin errors++; $display("FAIL fc7_eof got=\"%s\" to=%b exp=\"17\"", got_str(), col_to); end
    endtask

    task automatic test_cb();
        bus.iUopReady = 1;
        bus.iCbOp = 8'h7C;
        accept(8'hCB);
        collect();
        checks++;
        if (col_to || got_str() != "11 12 16") begin errors++; $display("FAIL cb_7c got=\"%s\" to=%b exp=\"11 12 16\"", got_str(), col_to); end
        bus.iCbOp = 8'h40;
        accept(8'hCB);
        collect();
        checks++;
        if (col_to || got_str() != "11 12 18 19") begin errors++; $display("FAIL cb_40 got=\"%s\" to=%b exp=\"11 12 18 19\"", got_str(), col_to); end
    endtask

    task automatic test_overflow();
        bus.iUopReady = 1;
        accept(8'hFF);
        collect();
        checks += 3;
        if (col_to || got_str() != "253 254 255") begin errors++; $display("FAIL ovf_seq got=\"%s\" to=%b exp=\"253 254 255\"", got_str(), col_to); end
        if (bus.oUpcOvf !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", bus.oUpcOvf); end
        if (bus.oUpc !== 8'd255 || bus.oUopValid !== 1'b0) begin
            errors++; $display("FAIL ovf_nowrap upc=%0d valid=%b exp upc=255 valid=0", bus.oUpc, bus.oUopValid);
        end
        accept(8'h00);
        collect();
        checks++;
        if (bus.oUpcOvf !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", bus.oUpcOvf); end
        bus.iFlagZ = 0;
        accept(8'h20);
        step();
        step();
        do_reset();
        checks++;
        if (bus.oUopValid !== 1'b0 || bus.oUop !== 13'd0 || bus.oUpc !== 8'd0 || bus.oUpcOvf !== 1'b0 || bus.oMopReady !== 1'b1) begin
            errors++;
            $display("FAIL midflow_reset valid=%b uop=%h upc=%0d ovf=%b mop_ready=%b exp 0/0/0/0/1",
                     bus.oUopValid, bus.oUop, bus.oUpc, bus.oUpcOvf, bus.oMopReady);
        end
    endtask

    task automatic test_reset_priority();
        bus.iMop = 8'h20;
        bus.iMopValid = 1;
        iReset = 1;
        step();
        iReset = 0;
        bus.iMopValid = 0;
        checks++;
        if (bus.oMopReady !== 1'b1 || bus.oUpc !== 8'd0) begin
            errors++; $display("FAIL reset_priority mop_ready=%b upc=%0d exp 1/0", bus.oMopReady, bus.oUpc);
        end
    endtask

    task automatic test_random();
        logic [7:0] ops [7] = '{8'h00, 8'h01, 8'h20, 8'h28, 8'hCB, 8'h76, 8'hFF};
        logic [7:0] op, cb;
        logic [12:0] pv;
        logic [7:0] pu;
        bit z, rdy, was_valid;
        int cyc, got;
        for (int f = 0; f < 40; f++) begin
            op = ($urandom_range(0, 7) == 7) ? 8'($urandom_range(0, 255)) : ops[$urandom_range(0, 6)];
            cb = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255)) : (($urandom_range(0, 1) == 1) ? 8'h7C : 8'h40);
            z = 1'($urandom_range(0, 1));
            model_flow(op, cb, z, 1'b0);
            bus.iCbOp = cb;
            bus.iFlagZ = z;
            bus.iUopReady = 0;
            accept(op);
            cyc = 0;
            got = 0;
            while (cyc < 200) begin
                if (!bus.oUopValid && bus.oMopReady) break;
                rdy = ($urandom_range(0, 2) != 0);
                bus.iUopReady = rdy;
                was_valid = bus.oUopValid;
                pu = bus.oUpc;
                pv = bus.oUop;
                if (was_valid && rdy) begin
                    checks++;
                    if (got >= exp_q.size() || pu !== 8'(exp_q[got]) || pv !== exp_uop(exp_q[got])) begin
                        errors++;
                        $display("FAIL rand_uop flow=%0d op=%h idx=%0d upc=%0d uop=%h exp upc=%0d uop=%h",
                                 f, op, got, pu, pv, (got < exp_q.size()) ? exp_q[got] : -1,
                                 (got < exp_q.size()) ? exp_uop(exp_q[got]) : 13'h0);
                    end
                    got++;
                end
                step();
                cyc++;
                if (was_valid && !rdy) begin
                    checks++;
                    if (bus.oUopValid !== 1'b1 || bus.oUpc !== pu || bus.oUop !== pv) begin
                        errors++;
                        $display("FAIL rand_hold flow=%0d valid=%b upc=%0d uop=%h exp valid=1 upc=%0d uop=%h",
                                 f, bus.oUopValid, bus.oUpc, bus.oUop, pu, pv);
                    end
                end
            end
            checks += 2;
            if (cyc >= 200 || got != exp_q.size()) begin
                errors++; $display("FAIL rand_count flow=%0d op=%h issued=%0d exp=%0d cycles=%0d", f, op, got, exp_q.size(), cyc);
            end
            if (bus.oUpcOvf !== exp_ovf) begin
                errors++; $display("FAIL rand_ovf flow=%0d op=%h got=%b exp=%b", f, op, bus.oUpcOvf, exp_ovf);
            end
            if (exp_ovf) do_reset();
        end
    endtask

`ifdef DZCPU_UCODE_INT_EN
    task automatic test_int();
        bus.iUopReady = 1;
        bus.iIrq = 1;
        model_flow(8'h01, 8'h00, 1'b0, 1'b1);
        accept(8'h01);
        collect();
        bus.iIrq = 0;
        checks++;
        if (col_to || got_str() != "1 2 3 4 163 164 165") begin
            errors++; $display("FAIL int_flow got=\"%s\" to=%b exp=\"1 2 3 4 163 164 165\"", got_str(), col_to);
        end
        checks++;
        if (exp_q.size() != got_q.size()) begin
            errors++; $display("FAIL int_model issued=%0d exp=%0d", got_q.size(), exp_q.size());
        end
    endtask
`endif

    initial begin
        test_reset();
        test_single_op();
        test_backpressure();
        test_cond_end();
        test_cb();
        test_overflow();
        test_reset_priority();
        test_random();
`ifdef DZCPU_UCODE_INT_EN
        test_int();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
